// File: rtl/cpu_tstate_sequencer.sv
// ============================================================================
// Module: cpu_tstate_sequencer
//
// Timing front end of the 6502 core. Generates the registered two-phase clock
// (phi1/phi2), walks the one-hot T-state, latches the opcode into OP while
// keeping the previous one in prevOP, and arbitrates RESET/NMI/IRQ by forcing
// a BRK opcode into the pipeline. The decoder's t_last output closes each
// instruction and returns the sequencer to T1.
//
// Parameters
//   BRK_OP        opcode forced into OP on interrupt/reset entry
//   NOP_OP        reset value of prevOP
//   RESET_HOLD_T  number of T0 T-states held after rst deasserts (>= 1)
//
// Ports
//   clk             in   system clock, one T-state = two clk cycles
//   rst             in   asynchronous reset, active-high
//   data_in[7:0]    in   data bus, captured as opcode at the end of T1
//   t_last          in   decoder flag: current T-state ends the instruction
//   rdy             in   0 stalls T-state advance
//   nmi_n           in   NMI request, falling-edge sensitive
//   irq_n           in   IRQ request, level, active-low
//   status_i        in   processor I flag, 1 masks IRQ
//   phi1, phi2      out  non-overlapping registered clock phases
//   T[6:0]          out  one-hot T-state, bit k = Tk
//   OP[7:0]         out  current opcode
//   prevOP[7:0]     out  previous opcode
//   activeInt[2:0]  out  000 none, 001 IRQ, 010 NMI, 100 RESET
//   sync            out  high throughout T1 (opcode fetch)
//   pc_inc_inhibit  out  high while an interrupt sequence is active
//   seq_err         out  sticky, T6 was left without t_last
//
// Optional feature (macro CYCLE_CNT_EN)
//   When defined, adds cycle_count[31:0] (T-states completed) and
//   instr_count[31:0] (T1->T2 transitions). Both wrap modulo 2^32.
// ============================================================================
module cpu_tstate_sequencer #(
    parameter logic [7:0] BRK_OP       = 8'h00,
    parameter logic [7:0] NOP_OP       = 8'hEA,
    parameter int         RESET_HOLD_T = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       t_last,
    input  logic       rdy,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       status_i,
    output logic       phi1,
    output logic       phi2,
    output logic [6:0] T,
    output logic [7:0] OP,
    output logic [7:0] prevOP,
    output logic [2:0] activeInt,
    output logic       sync,
    output logic       pc_inc_inhibit,
    output logic       seq_err
`ifdef CYCLE_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    // Width of the post-reset hold counter; at least one bit so a hold of a
    // single T-state still has a legal register.
    localparam int HOLD_W = (RESET_HOLD_T > 1) ? $clog2(RESET_HOLD_T) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_T - 1);

    localparam logic [2:0] INT_NONE  = 3'b000;
    localparam logic [2:0] INT_IRQ   = 3'b001;
    localparam logic [2:0] INT_NMI   = 3'b010;
    localparam logic [2:0] INT_RESET = 3'b100;

    typedef enum logic [6:0] {
        T0 = 7'b0000001,
        T1 = 7'b0000010,
        T2 = 7'b0000100,
        T3 = 7'b0001000,
        T4 = 7'b0010000,
        T5 = 7'b0100000,
        T6 = 7'b1000000
    } tState_t;

    tState_t            state;
    tState_t            nextState;
    logic [7:0]         nextOp;
    logic [7:0]         nextPrevOp;
    logic [2:0]         nextActiveInt;
    logic [HOLD_W-1:0]  holdCnt;
    logic [HOLD_W-1:0]  nextHoldCnt;
    logic               nextSeqErr;
    logic               nmiLatch;
    logic               nextNmiLatch;
    logic               nmiPrev;
    logic               boundary;
    logic               advance;
    logic               irqRequest;

    // The boundary edge is the clk edge that ends phi2; all architectural
    // state moves only there, and only when rdy lets the T-state advance.
    assign boundary   = phi2;
    assign advance    = boundary && rdy;
    assign irqRequest = !irq_n && !status_i;

    assign T              = state;
    assign sync           = (state == T1);
    assign pc_inc_inhibit = (activeInt != INT_NONE);

    // Phase generator: the two phases simply swap every clk, starting with
    // phi1 high out of reset so the first boundary is two clk edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phi1 <= 1'b1;
            phi2 <= 1'b0;
        end else begin
            phi1 <= ~phi1;
            phi2 <= ~phi2;
        end
    end

    // NMI input history, sampled once per T-state on the edge ending phi1.
    // It keeps running through rdy stalls so an edge is never missed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmiPrev <= 1'b1;
        end else if (phi1) begin
            nmiPrev <= nmi_n;
        end
    end

    // Architectural state register: T-state, opcodes, interrupt status,
    // post-reset hold counter, sticky error and the NMI edge latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= T0;
            OP        <= BRK_OP;
            prevOP    <= NOP_OP;
            activeInt <= INT_RESET;
            holdCnt   <= '0;
            seq_err   <= 1'b0;
            nmiLatch  <= 1'b0;
        end else begin
            state     <= nextState;
            OP        <= nextOp;
            prevOP    <= nextPrevOp;
            activeInt <= nextActiveInt;
            holdCnt   <= nextHoldCnt;
            seq_err   <= nextSeqErr;
            nmiLatch  <= nextNmiLatch;
        end
    end

    // Next-state logic. The NMI latch is set on the phi1 sampling edge and
    // cleared on injection at a boundary edge; those never coincide, so the
    // two updates cannot fight. Interrupt arbitration happens only when T1
    // is left: NMI wins over IRQ, and an IRQ losing that race is not stored,
    // it is simply seen again at the next T1 if still asserted. Leaving the
    // last T-state of any instruction (including a forced T6 exit) ends the
    // interrupt sequence that the BRK was serving.
    always_comb begin
        nextState     = state;
        nextOp        = OP;
        nextPrevOp    = prevOP;
        nextActiveInt = activeInt;
        nextHoldCnt   = holdCnt;
        nextSeqErr    = seq_err;
        nextNmiLatch  = nmiLatch;

        if (phi1 && nmiPrev && !nmi_n) begin
            nextNmiLatch = 1'b1;
        end

        if (advance) begin
            case (state)
                T0: begin
                    if (holdCnt == HOLD_LAST) begin
                        nextState   = T2;
                        nextHoldCnt = '0;
                    end else begin
                        nextHoldCnt = holdCnt + 1'b1;
                    end
                end
                T1: begin
                    nextState  = T2;
                    nextPrevOp = OP;
                    if (nmiLatch) begin
                        nextOp        = BRK_OP;
                        nextActiveInt = INT_NMI;
                        nextNmiLatch  = 1'b0;
                    end else if (irqRequest) begin
                        nextOp        = BRK_OP;
                        nextActiveInt = INT_IRQ;
                    end else begin
                        nextOp = data_in;
                    end
                end
                T2: begin
                    if (t_last) begin
                        nextState     = T1;
                        nextActiveInt = INT_NONE;
                    end else begin
                        nextState = T3;
                    end
                end
                T3: begin
                    if (t_last) begin
                        nextState     = T1;
                        nextActiveInt = INT_NONE;
                    end else begin
                        nextState = T4;
                    end
                end
                T4: begin
                    if (t_last) begin
                        nextState     = T1;
                        nextActiveInt = INT_NONE;
                    end else begin
                        nextState = T5;
                    end
                end
                T5: begin
                    if (t_last) begin
                        nextState     = T1;
                        nextActiveInt = INT_NONE;
                    end else begin
                        nextState = T6;
                    end
                end
                T6: begin
                    // T6 is the longest legal instruction; leave anyway so a
                    // decoder fault cannot hang the core, but remember it.
                    nextState     = T1;
                    nextActiveInt = INT_NONE;
                    if (!t_last) begin
                        nextSeqErr = 1'b1;
                    end
                end
                default: begin
                    nextState = T0;
                end
            endcase
        end
    end

`ifdef CYCLE_CNT_EN
    // Performance counters: one count per completed T-state and one per
    // opcode fetch. Both wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else if (advance) begin
            cycle_count <= cycle_count + 32'd1;
            if (state == T1) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end
`endif

endmodule
